// File: rtl/isp_stat_awb.sv
// Per-frame AWB statistics: R/G/B site sums and Bayer-quad count over a raw stream,
// published with a one-cycle stat_done pulse at the start of the next frame.
module isp_stat_awb #(
    parameter int          BITS  = 8,
    parameter int unsigned BAYER = 0
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            stat_en,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_raw,
    output logic            stat_done,
    output logic [31:0]     pix_cnt,
    output logic [31:0]     sum_r,
    output logic [31:0]     sum_g,
    output logic [31:0]     sum_b
);
    localparam logic [1:0] PHASE = 2'(BAYER);

    logic            href_q, href_qq, vs_q, vs_qq;
    logic [BITS-1:0] raw_q;
    logic            row, col, frame_active;
    logic [31:0]     acc_r, acc_b, acc_cnt;
    logic [32:0]     acc_g;

    logic            vs_rise, href_rise, href_fall, acc_en;
    logic            row_eff, col_eff;
    logic [1:0]      site;
    logic [31:0]     pix;
    logic [31:0]     nxt_r, nxt_b, nxt_cnt;
    logic [32:0]     nxt_g;

    function automatic logic [31:0] sat32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    function automatic logic [32:0] sat33(input logic [32:0] a, input logic [31:0] b);
        logic [33:0] s;
        s = {1'b0, a} + {2'b0, b};
        return s[33] ? '1 : s[32:0];
    endfunction

    assign vs_rise   = vs_q & ~vs_qq;
    assign href_rise = href_q & ~href_qq;
    assign href_fall = ~href_q & href_qq;
    assign pix       = 32'(raw_q);

    // A pixel coincident with vs_rise belongs to the new frame at its (0,0) site.
    assign row_eff = vs_rise ? 1'b0 : row;
    assign col_eff = (vs_rise | href_rise) ? 1'b0 : col;
    assign site    = PHASE ^ {row_eff, col_eff};
    assign acc_en  = vs_rise ? stat_en : frame_active;

    always_comb begin
        nxt_r   = vs_rise ? '0 : acc_r;
        nxt_g   = vs_rise ? '0 : acc_g;
        nxt_b   = vs_rise ? '0 : acc_b;
        nxt_cnt = vs_rise ? '0 : acc_cnt;
        if (href_q && acc_en) begin
            case (site)
                2'd0: begin
                    nxt_r   = sat32(nxt_r, pix);
                    nxt_cnt = sat32(nxt_cnt, 32'd1);
                end
                2'd3:    nxt_b = sat32(nxt_b, pix);
                default: nxt_g = sat33(nxt_g, pix);
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            href_q       <= 1'b0;
            href_qq      <= 1'b0;
            vs_q         <= 1'b0;
            vs_qq        <= 1'b0;
            raw_q        <= '0;
            row          <= 1'b0;
            col          <= 1'b0;
            frame_active <= 1'b0;
            acc_r        <= '0;
            acc_g        <= '0;
            acc_b        <= '0;
            acc_cnt      <= '0;
            stat_done    <= 1'b0;
            pix_cnt      <= '0;
            sum_r        <= '0;
            sum_g        <= '0;
            sum_b        <= '0;
        end else begin
            href_q  <= in_href;
            href_qq <= href_q;
            vs_q    <= in_vsync;
            vs_qq   <= vs_q;
            raw_q   <= in_raw;
            col     <= href_q ? ~col_eff : col;
            row     <= vs_rise ? 1'b0 : (href_fall ? ~row : row);
            acc_r   <= nxt_r;
            acc_g   <= nxt_g;
            acc_b   <= nxt_b;
            acc_cnt <= nxt_cnt;
            if (vs_rise)
                frame_active <= stat_en;
            stat_done <= vs_rise & frame_active;
            if (vs_rise && frame_active) begin
                pix_cnt <= acc_cnt;
                sum_r   <= acc_r;
                sum_g   <= acc_g[32:1];
                sum_b   <= acc_b;
            end
        end
    end
endmodule

// File: tb/tb_isp_stat_awb.sv
// Randomized frame-level bench for isp_stat_awb (RGGB and BGGR instances side by side),
// checked against per-frame site sums computed from pixel coordinates.
module tb_isp_stat_awb;
    localparam int     BITS  = 8;
    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAX33 = 64'h0000_0001_FFFF_FFFF;

    typedef logic [1:0][3:0][31:0] res_t;
    typedef struct {
        int   cyc;
        res_t v;
    } exp_t;

    logic            pclk = 1'b0;
    logic            rst = 1'b1, stat_en = 1'b0, in_href = 1'b0, in_vsync = 1'b0;
    logic [BITS-1:0] in_raw = '0;
    logic            stat_done [2];
    logic [31:0]     pix_cnt [2], sum_r [2], sum_g [2], sum_b [2];

    int   checks = 0, fails = 0, npulse = 0, nexp = 0, cyc = 0;
    bit   active = 1'b0;
    res_t cur = '0, last = '0;
    exp_t expq[$];
    int   pix [8][8];

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    isp_stat_awb #(.BITS(BITS), .BAYER(0)) u_awb0 (
        .pclk(pclk), .rst(rst), .stat_en(stat_en), .in_href(in_href), .in_vsync(in_vsync),
        .in_raw(in_raw), .stat_done(stat_done[0]), .pix_cnt(pix_cnt[0]), .sum_r(sum_r[0]),
        .sum_g(sum_g[0]), .sum_b(sum_b[0]));

    isp_stat_awb #(.BITS(BITS), .BAYER(3)) u_awb3 (
        .pclk(pclk), .rst(rst), .stat_en(stat_en), .in_href(in_href), .in_vsync(in_vsync),
        .in_raw(in_raw), .stat_done(stat_done[1]), .pix_cnt(pix_cnt[1]), .sum_r(sum_r[1]),
        .sum_g(sum_g[1]), .sum_b(sum_b[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge pclk);
        #1;
    endtask

    function automatic logic [31:0] obs(input int i, input int k);
        case (k)
            0:       return pix_cnt[i];
            1:       return sum_r[i];
            2:       return sum_g[i];
            default: return sum_b[i];
        endcase
    endfunction

    function automatic string fld(input int k);
        case (k)
            0:       return "cnt";
            1:       return "r";
            2:       return "g";
            default: return "b";
        endcase
    endfunction

    task automatic check_outputs(input string pre, input res_t e);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s_dut%0d_%s", pre, i, fld(k)), 64'(obs(i, k)), 64'(e[i][k]));
    endtask

    // Frame statistics straight from pixel coordinates: site = phase XOR {row&1, col&1}.
    function automatic logic [3:0][31:0] model(input int b, input int rows, input int cols,
                                               input longint pr, input longint pg, input longint pn);
        longint sr = pr, sg = pg, sb = 0, sn = pn;
        logic [3:0][31:0] res;
        for (int i = 0; i < rows; i++)
            for (int j = 0; j < cols; j++) begin
                int s = b ^ (((i % 2) * 2) + (j % 2));
                if (s == 0) begin
                    sr += pix[i][j];
                    sn++;
                end else if (s == 3) sb += pix[i][j];
                else sg += pix[i][j];
            end
        res[0] = 32'(sn > MAX32 ? MAX32 : sn);
        res[1] = 32'(sr > MAX32 ? MAX32 : sr);
        res[2] = 32'((sg > MAX33 ? MAX33 : sg) >> 1);
        res[3] = 32'(sb > MAX32 ? MAX32 : sb);
        return res;
    endfunction

    initial forever begin
        exp_t e;
        @(posedge pclk);
        #1;
        if (stat_done[0] || stat_done[1]) begin
            npulse++;
            if (expq.size() == 0) begin
                chk("unexpected_pulse_dut0", 64'(stat_done[0]), 64'd0);
                chk("unexpected_pulse_dut3", 64'(stat_done[1]), 64'd0);
            end else begin
                e = expq.pop_front();
                chk("pulse_latency", 64'(cyc), 64'(e.cyc));
                chk("done_dut0", 64'(stat_done[0]), 64'd1);
                chk("done_dut3", 64'(stat_done[1]), 64'd1);
                check_outputs("stat", e.v);
                last = e.v;
            end
        end
    end

    task automatic run_frame(input int rows, input int cols, input bit en, input bit coinc,
                             input bit sat, input bit rst_mid);
        longint pr, pg, pn;
        exp_t   e;
        check_outputs("hold", last);
        if (active) begin
            e.cyc = cyc + 2;
            e.v   = cur;
            expq.push_back(e);
            nexp++;
        end
        active = en;
        pr = sat ? 64'hFFFF_FF00 : 0;
        pg = sat ? 64'h1_FFFF_FF00 : 0;
        pn = sat ? 64'hFFFF_FFFE : 0;
        cur[0] = model(0, rows, cols, pr, pg, pn);
        cur[1] = model(3, rows, cols, pr, pg, pn);

        in_vsync = 1'b1;
        stat_en  = en;
        if (coinc) begin
            in_href = 1'b1;
            in_raw  = BITS'(pix[0][0]);
            step;
        end else begin
            in_href = 1'b0;
            step;
            step;
        end
        if (sat) begin
            u_awb0.acc_r = 32'hFFFF_FF00; u_awb0.acc_g = 33'h1_FFFF_FF00; u_awb0.acc_cnt = 32'hFFFF_FFFE;
            u_awb3.acc_r = 32'hFFFF_FF00; u_awb3.acc_g = 33'h1_FFFF_FF00; u_awb3.acc_cnt = 32'hFFFF_FFFE;
        end
        for (int i = 0; i < rows; i++) begin
            for (int j = (coinc && i == 0) ? 1 : 0; j < cols; j++) begin
                in_href = 1'b1;
                in_raw  = BITS'(pix[i][j]);
                step;
            end
            in_href = 1'b0;
            step;
            if (i == 0) begin
                in_vsync = 1'b0;
                stat_en  = 1'($urandom);
            end
            if (rst_mid && i == 1) begin
                rst = 1'b1;
                step;
                check_outputs("rst_mid", '0);
                chk("rst_mid_done0", 64'(stat_done[0]), 64'd0);
                chk("rst_mid_done3", 64'(stat_done[1]), 64'd0);
                rst    = 1'b0;
                active = 1'b0;
                last   = '0;
            end
        end
        step;
    endtask

    task automatic fill_random;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                pix[i][j] = int'($urandom_range(0, 255));
    endtask

    task automatic fill_quad(input int r, input int gr, input int gb, input int b);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                pix[i][j] = (i % 2) ? ((j % 2) ? b : gb) : ((j % 2) ? gr : r);
    endtask

    initial begin
        repeat (3) step;
        check_outputs("reset", '0);
        chk("reset_done0", 64'(stat_done[0]), 64'd0);
        chk("reset_done3", 64'(stat_done[1]), 64'd0);
        rst = 1'b0;
        step;

        fill_quad(100, 50, 70, 30);
        run_frame(4, 4, 1, 0, 0, 0);      // first vsync: nothing to report
        run_frame(4, 4, 1, 0, 0, 0);      // reports 400/240/120/4 (swapped R/B for BGGR)
        fill_random; run_frame(4, 6, 0, 0, 0, 0);   // disabled frame
        fill_random; run_frame(5, 4, 1, 0, 0, 0);   // no pulse, outputs hold
        fill_random; run_frame(4, 4, 1, 0, 0, 0);
        fill_random; pix[0][0] = 9;
        run_frame(4, 4, 1, 1, 0, 0);      // pixel 9 rides the vsync edge
        fill_quad(255, 255, 255, 255);
        run_frame(4, 4, 1, 0, 1, 0);      // preloaded near max: must saturate
        fill_random; run_frame(6, 6, 1, 0, 0, 1);   // reset mid-frame
        fill_random; run_frame(4, 4, 1, 0, 0, 0);   // no pulse after reset
        fill_random; run_frame(4, 4, 1, 0, 0, 0);
        for (int n = 0; n < 8; n++) begin
            fill_random;
            run_frame(int'($urandom_range(2, 8)), int'($urandom_range(2, 8)),
                      ($urandom_range(0, 3) != 0), 1'($urandom), 0, 0);
        end
        fill_random; run_frame(2, 2, 0, 0, 0, 0);
        repeat (5) step;
        chk("pending_expected", 64'(expq.size()), 64'd0);
        chk("pulse_count", 64'(npulse), 64'(nexp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/isp_stat_awb.md
Name: isp_stat_awb

Overview:
- Per-frame white-balance statistics collector for a raw Bayer stream.
- Sits in the ISP datapath before the AWB gain stage.
- Accumulates R, averaged G and B sums plus a Bayer-quad count over each frame.
- On each frame boundary, publishes the results with a one-cycle stat_done pulse; downstream gain computation consumes sum_g / (sum_r>>4) as a 4.4 gain.

Parameters:
- BITS, 8, raw pixel width (8..16).
- BAYER, 0, CFA phase of the first pixel of a frame: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- stat_en  in  1  enable; sampled at frame start (vsync rise).
- in_href  in  1  line-valid; pixel on in_raw is valid while high.
- in_vsync  in  1  frame sync; rising edge marks frame start / end of previous frame.
- in_raw  in  BITS  raw Bayer pixel.
- stat_done  out  1  one-cycle pulse; outputs below are valid and held until the next pulse.
- pix_cnt  out  32  number of R sites (Bayer quads) accumulated.
- sum_r  out  32  sum of R pixels.
- sum_g  out  32  (sum of Gr + Gb) >> 1.
- sum_b  out  32  sum of B pixels.

Behaviour:
- Reset (synchronous, active-high): stat_done=0, pix_cnt=sum_r=sum_g=sum_b=0. All accumulators, parity flags, registered vsync/href and frame_active are cleared.
- Input stage: in_href, in_vsync and in_raw are registered once. Edge detection runs on the registered signals: vs_rise = vs_q & ~vs_qq.
- Site tracking:
  - col parity resets to 0 on href rise and toggles after each valid pixel.
  - row parity resets to 0 on vs_rise and toggles on each href fall.
  - Site = BAYER XOR {row, col}, with bit1 = row and bit0 = col.
  - For RGGB: 00 = R, 01 = Gr, 10 = Gb, 11 = B. Other BAYER values remap by the XOR.
- Accumulators:
  - acc_r, acc_b and acc_cnt are 32 bits; acc_g is 33 bits.
  - Each valid pixel adds in_raw (zero-extended) to its site's accumulator.
  - acc_cnt increments on each R site.
  - All accumulators saturate at all-ones and never wrap.
  - Accumulation occurs only while frame_active=1.
- Frame boundary (vs_rise cycle):
  - If frame_active=1: the next cycle loads pix_cnt, sum_r, sum_g (= acc_g[32:1]) and sum_b from the accumulators, and stat_done=1 for exactly that cycle.
  - If frame_active=0: no pulse, and outputs are unchanged.
  - In the same cycle, accumulators clear, and frame_active <= stat_en.
- Latency: stat_done rises 2 pclk cycles after the in_vsync rising edge is presented.
- Simultaneous vs_rise and a valid pixel:
  - The snapshot uses the old accumulator values.
  - That pixel, if frame_active is becoming 1, is loaded as the initial value of its new-frame accumulator (row=0, col=0 site) rather than lost.
- Frame activity:
  - The first vs_rise after reset never pulses, because no complete frame exists.
  - A frame with stat_en=0 at its start is not accumulated, and the following vs_rise does not pulse.
- Pixels presented while in_vsync is high are accumulated like any other; only the rising edge of in_vsync matters.
- Reset mid-frame: the partial frame is discarded, and the next vs_rise produces no pulse.

Test Plan:
- Reset, then stat_en=1, two 4x4 RGGB frames with R=100, Gr=50, Gb=70, B=30 -> one stat_done at frame-2 vsync rise +2 cycles. Values: pix_cnt=4, sum_r=400, sum_g=240, sum_b=120. No pulse at the first vsync.
- Same frame data with BAYER=3 (BGGR) -> sum_r=120, sum_b=400, sum_g=240, pix_cnt=4.
- BITS=8, all pixels 255, frame of 2^25 quads (or accumulators force-preloaded near max) -> sum_r=32'hFFFFFFFF saturated, no wrap.
- stat_en=0 at the start of frame N -> no stat_done at the end of frame N; outputs hold the frame N-1 values. Re-enable -> pulse resumes at the end of frame N+1.
- Valid pixel (value 9, R site) coincident with vsync rise -> previous frame sums exclude it; next frame sum_r includes 9.
- rst asserted mid-frame for 1 cycle -> all outputs 0; next vsync no pulse; the following frame reports correct sums.
